dff_delay_line: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with per-stage valid tracking, stall, flush, a runtime-selectable tap and an occupancy count.
- Used wherever the design needs aligned fixed-latency delays, such as matching datapath latency to control paths or retiming buses across modules.

---
 rtl/dff_delay_line_if.sv | 41 ++++
 rtl/dff_delay_line.sv | 141 ++++++++++++++
 tb/tb_dff_delay_line.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dff_delay_line_if.sv
// Bus bundle for dff_delay_line: pipeline controls, data/valid input, tap select and all outputs.
// Define DFF_DELAY_LINE_PARITY_EN to add err_inject / parity_err.
interface dff_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d_in;
    logic             vld_in;
    logic [TAP_W-1:0] tap_sel;
    logic [WIDTH-1:0] q;
    logic             vld_out;
    logic [WIDTH-1:0] tap_q;
    logic             tap_vld;
    logic [CNT_W-1:0] occupancy;
`ifdef DFF_DELAY_LINE_PARITY_EN
    logic             err_inject;
    logic             parity_err;

    modport master (
        output en, flush, d_in, vld_in, tap_sel, err_inject,
        input  q, vld_out, tap_q, tap_vld, occupancy, parity_err
    );
    modport slave (
        input  en, flush, d_in, vld_in, tap_sel, err_inject,
        output q, vld_out, tap_q, tap_vld, occupancy, parity_err
    );
`else
    modport master (
        output en, flush, d_in, vld_in, tap_sel,
        input  q, vld_out, tap_q, tap_vld, occupancy
    );
    modport slave (
        input  en, flush, d_in, vld_in, tap_sel,
        output q, vld_out, tap_q, tap_vld, occupancy
    );
`endif
endinterface

// File: rtl/dff_delay_line.sv
// WIDTH x DEPTH register delay line with valid tracking, stall, flush, runtime tap and occupancy.
// Optional per-stage parity with sticky error flag when DFF_DELAY_LINE_PARITY_EN is defined.
module dff_delay_line #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               TAP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    dff_delay_line_if.slave     bus
);
    logic [DEPTH-1:0][WIDTH-1:0] stage_reg;
    logic [DEPTH-1:0][WIDTH-1:0] stage_next;
    logic [DEPTH-1:0]            vld_reg;
    logic [DEPTH-1:0]            vld_next;
    logic [CNT_W-1:0]            occupancy_reg;
    logic [CNT_W-1:0]            occupancy_next;
    logic [WIDTH-1:0]            tap_data;
    logic                        tap_valid;

    // Source of each stage when the line advances: d_in for stage 0, the previous stage otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = bus.d_in;
                assign vld_next[gi]   = bus.vld_in;
            end else begin : g_body
                assign stage_next[gi] = stage_reg[gi-1];
                assign vld_next[gi]   = vld_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_reg <= {DEPTH{RESET_VAL}};
            vld_reg   <= '0;
        end else if (bus.flush) begin
            stage_reg <= {DEPTH{RESET_VAL}};
            vld_reg   <= '0;
        end else if (bus.en) begin
            stage_reg <= stage_next;
            vld_reg   <= vld_next;
        end
    end

    // Tracked incrementally so it equals popcount(vld_reg) without an adder tree.
    always_comb begin
        occupancy_next = occupancy_reg;
        if (bus.en) begin
            occupancy_next = occupancy_reg + CNT_W'(bus.vld_in) - CNT_W'(vld_reg[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy_reg <= '0;
        end else if (bus.flush) begin
            occupancy_reg <= '0;
        end else begin
            occupancy_reg <= occupancy_next;
        end
    end

    generate
        if (DEPTH == 1) begin : g_tap_single
            assign tap_data  = stage_reg[0];
            assign tap_valid = vld_reg[0];
        end else begin : g_tap_mux
            // Out-of-range selects fall through to the reset value with no valid.
            always_comb begin
                tap_data  = RESET_VAL;
                tap_valid = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (bus.tap_sel == TAP_W'(i)) begin
                        tap_data  = stage_reg[i];
                        tap_valid = vld_reg[i];
                    end
                end
            end
        end
    endgenerate

    assign bus.q         = stage_reg[DEPTH-1];
    assign bus.vld_out   = vld_reg[DEPTH-1];
    assign bus.tap_q     = tap_data;
    assign bus.tap_vld   = tap_valid;
    assign bus.occupancy = occupancy_reg;

`ifdef DFF_DELAY_LINE_PARITY_EN
    localparam logic RESET_PAR = ^RESET_VAL;

    logic [DEPTH-1:0] par_reg;
    logic [DEPTH-1:0] par_next;
    logic             parity_err_reg;
    logic             parity_err_next;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_par
            if (gi == 0) begin : g_head
                assign par_next[gi] = (^bus.d_in) ^ bus.err_inject;
            end else begin : g_body
                assign par_next[gi] = par_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_reg <= {DEPTH{RESET_PAR}};
        end else if (bus.flush) begin
            par_reg <= {DEPTH{RESET_PAR}};
        end else if (bus.en) begin
            par_reg <= par_next;
        end
    end

    // Sticky: once a valid output word disagrees with its parity, hold until flush/reset.
    always_comb begin
        parity_err_next = parity_err_reg;
        if (vld_reg[DEPTH-1] && ((^stage_reg[DEPTH-1]) != par_reg[DEPTH-1])) begin
            parity_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err_reg <= 1'b0;
        end else if (bus.flush) begin
            parity_err_reg <= 1'b0;
        end else begin
            parity_err_reg <= parity_err_next;
        end
    end

    assign bus.parity_err = parity_err_reg;
`endif
endmodule

// File: tb/tb_dff_delay_line.sv
// Directed bench for dff_delay_line (WIDTH=8, DEPTH=4, RESET_VAL=0); parity steps
// run only when DFF_DELAY_LINE_PARITY_EN is defined.
module tb_dff_delay_line;
    logic clk;
    logic rst_n;
    int   check_cnt;
    int   pass_cnt;
    int   fail_cnt;

    dff_delay_line_if #(.WIDTH(8), .DEPTH(4)) bus ();

    dff_delay_line #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input string what);
        @(posedge clk);
        #1;
        $display("[%0t] %s: q=%h vld_out=%b occ=%0d", $time, what, bus.q, bus.vld_out, bus.occupancy);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] lat_q   [5] = '{8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2};
    logic       lat_v   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] lat_occ [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [7:0] tap_exp [4] = '{8'h33, 8'h22, 8'h11, 8'h00};
    logic       tapv_exp[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        rst_n       = 1'b0;
        bus.en      = 1'b1;
        bus.flush   = 1'b0;
        bus.d_in    = 8'hFF;
        bus.vld_in  = 1'b1;
        bus.tap_sel = 2'd0;
`ifdef DFF_DELAY_LINE_PARITY_EN
        bus.err_inject = 1'b0;
`endif

        // Reset held: inputs active but nothing captured
        for (int i = 0; i < 3; i++) begin
            tick("reset");
            chk("reset_q", 32'(bus.q), 32'h00);
            chk("reset_vld_out", 32'(bus.vld_out), 32'h0);
            chk("reset_occ", 32'(bus.occupancy), 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick("post_reset");
            chk("post_reset_vld_out", 32'(bus.vld_out), 32'h0);
            chk("post_reset_occ", 32'(bus.occupancy), 32'(i));
        end

        bus.flush = 1'b1;
        tick("flush");
        bus.flush = 1'b0;
        chk("flush_occ", 32'(bus.occupancy), 32'h0);

        // Latency: A1..A5 on consecutive enabled edges
        for (int i = 0; i < 5; i++) begin
            bus.d_in = 8'hA1 + 8'(i);
            tick("latency");
            chk("lat_q", 32'(bus.q), 32'(lat_q[i]));
            chk("lat_vld_out", 32'(bus.vld_out), 32'(lat_v[i]));
            chk("lat_occ", 32'(bus.occupancy), 32'(lat_occ[i]));
        end

        // Stall
        bus.flush = 1'b1;
        tick("flush");
        bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.d_in = 8'hA1 + 8'(i);
            tick("load");
        end
        chk("load_q", 32'(bus.q), 32'hA1);
        bus.en   = 1'b0;
        bus.d_in = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick("stall");
            chk("stall_q", 32'(bus.q), 32'hA1);
            chk("stall_vld_out", 32'(bus.vld_out), 32'h1);
            chk("stall_occ", 32'(bus.occupancy), 32'h4);
        end
        bus.en   = 1'b1;
        bus.d_in = 8'hA5;
        tick("resume");
        chk("resume_q", 32'(bus.q), 32'hA2);
        chk("resume_occ", 32'(bus.occupancy), 32'h4);

        // Flush and enable together: flush wins, 0x55 not captured
        bus.d_in  = 8'h55;
        bus.flush = 1'b1;
        tick("flush_en");
        bus.flush = 1'b0;
        bus.en    = 1'b0;
        chk("flush_en_q", 32'(bus.q), 32'h00);
        chk("flush_en_vld_out", 32'(bus.vld_out), 32'h0);
        chk("flush_en_occ", 32'(bus.occupancy), 32'h0);
        chk("flush_en_tap_q", 32'(bus.tap_q), 32'h00);
        chk("flush_en_tap_vld", 32'(bus.tap_vld), 32'h0);

        // Tap sweep with a bubble in the middle
        bus.en = 1'b1;
        bus.d_in = 8'h11; bus.vld_in = 1'b1; tick("push_11");
        bus.d_in = 8'h22; bus.vld_in = 1'b0; tick("push_22");
        bus.d_in = 8'h33; bus.vld_in = 1'b1; tick("push_33");
        bus.en = 1'b0;
        chk("tap_occ", 32'(bus.occupancy), 32'h2);
        chk("tap_vld_out", 32'(bus.vld_out), 32'h0);
        for (int t = 0; t < 4; t++) begin
            bus.tap_sel = 2'(t);
            #1;
            $display("[%0t] tap_sel=%0d: tap_q=%h tap_vld=%b", $time, t, bus.tap_q, bus.tap_vld);
            chk("tap_q", 32'(bus.tap_q), 32'(tap_exp[t]));
            chk("tap_vld", 32'(bus.tap_vld), 32'(tapv_exp[t]));
        end

`ifdef DFF_DELAY_LINE_PARITY_EN
        chk("parity_clean", 32'(bus.parity_err), 32'h0);
        bus.flush = 1'b1;
        tick("flush");
        bus.flush = 1'b0;
        bus.en = 1'b1;
        bus.d_in = 8'h0F; bus.vld_in = 1'b1; bus.err_inject = 1'b1; tick("push_0F_bad");
        bus.err_inject = 1'b0;
        bus.d_in = 8'hF0; tick("push_F0");
        bus.d_in = 8'h00; bus.vld_in = 1'b0; tick("push_bubble");
        tick("push_bubble");
        chk("par_q_0F", 32'(bus.q), 32'h0F);
        chk("par_vld_0F", 32'(bus.vld_out), 32'h1);
        chk("par_err_before", 32'(bus.parity_err), 32'h0);
        tick("shift");
        chk("par_q_F0", 32'(bus.q), 32'hF0);
        chk("par_err_set", 32'(bus.parity_err), 32'h1);
        bus.en = 1'b0;
        tick("hold");
        tick("hold");
        chk("par_err_sticky", 32'(bus.parity_err), 32'h1);
        bus.flush = 1'b1;
        tick("flush");
        bus.flush = 1'b0;
        chk("par_err_flushed", 32'(bus.parity_err), 32'h0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
